// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC, ROM address drive and prefetch queue to decode.
// Ports: clk/reset, imem_addr/imem_data, redirect/redirect_pc, instr_valid/instr/instr_pc/instr_ready.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   epc_q [DEPTH];
  logic [31:0]   ewd_q [DEPTH];

  logic pop;
  logic push;

  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? ewd_q[rd_q] : '0;
  assign instr_pc    = instr_valid ? epc_q[rd_q] : '0;

  assign pop  = instr_valid & instr_ready;
  // A pop frees the head slot this cycle, so a full queue still accepts.
  assign push = ~redirect & ((cnt_q < FULL) | pop);

  always_comb begin
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect) begin
      pc_d  = redirect_pc & 32'hFFFF_FFFC;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + P_ONE;
      end
      if (pop) begin
        rd_d = rd_q + P_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + C_ONE;
        2'b01:   cnt_d = cnt_q - C_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        epc_q[i] <= '0;
        ewd_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push) begin
        epc_q[wr_q] <= pc_q;
        ewd_q[wr_q] <= imem_data;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random stimulus against a queue-based model.
// Drives ifetch_queue with a synthetic combinational ROM.
module tb_ifetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = rom(imem_addr);

  ifetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] q_pc [$];
  logic [31:0] q_w  [$];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rs, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    logic [31:0] e_w;
    logic [31:0] e_p;
    logic        e_v;
    logic        m_pop;
    reset       = rs;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    e_v = (q_pc.size() != 0);
    e_w = e_v ? q_w[0]  : 32'h0;
    e_p = e_v ? q_pc[0] : 32'h0;
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_v});
    chk("instr", instr, e_w);
    chk("instr_pc", instr_pc, e_p);
    chk("count", 32'(dut.cnt_q), 32'(q_pc.size()));
    if (rs) begin
      q_pc.delete();
      q_w.delete();
      m_pc = RST_PC;
    end else begin
      m_pop = e_v && rdy;
      if (rd) begin
        q_pc.delete();
        q_w.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (m_pop) begin
          void'(q_pc.pop_front());
          void'(q_w.pop_front());
        end
        if (q_pc.size() < DEPTH) begin
          q_pc.push_back(m_pc);
          q_w.push_back(rom(m_pc));
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    m_pc        = RST_PC;
    @(posedge clk);
    @(negedge clk);

    // streaming with ready held high
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // backpressure until full
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("bp_addr", imem_addr, 32'h10);
    chk("bp_pc", instr_pc, 32'h0);
    chk("bp_count", 32'(dut.cnt_q), 32'd4);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // redirect while full
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0013, 0);
    chk("rd_addr", imem_addr, 32'h10);
    chk("rd_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 0, 0, 0);
    chk("rd_pc", instr_pc, 32'h10);
    chk("rd_word", instr, rom(32'h10));

    // redirect with a simultaneous head handshake
    step(0, 0, 0, 1);
    step(0, 1, 32'h0000_0100, 1);
    chk("rdh_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("rdh_pc", instr_pc, 32'h100);

    // wrap-around of the fetch PC
    step(0, 1, 32'hFFFF_FFF8, 1);
    chk("wrap0", imem_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("wrap1", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap2", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // reset mid-stream with three entries queued
    step(0, 1, 32'h40, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("mid_count", 32'(dut.cnt_q), 32'd3);
    step(1, 1, 32'h80, 1);
    chk("mid_valid", {31'b0, instr_valid}, 32'h0);
    chk("mid_addr", imem_addr, RST_PC);
    chk("mid_instr", instr, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
